// File: rtl/myproject.sv
// Pulse-parameter extractor: weighted centroid (Mean) and RMS width (Sigma) of one
// captured waveform, computed sequentially behind an ap_ctrl_hs style handshake.
module myproject #(
    parameter int N_SAMP = 100,
    parameter int IN_W = 18,
    parameter int OUT_W = 24,
    parameter logic signed [IN_W-1:0] BASELINE = '0
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic                     ap_start,
    output logic                     ap_done,
    output logic                     ap_idle,
    output logic                     ap_ready,
    input  logic [N_SAMP*IN_W-1:0]   input_1,
    input  logic                     input_1_ap_vld,
    output logic [OUT_W-1:0]         layer5_out_0,
    output logic [OUT_W-1:0]         layer5_out_1,
    output logic                     layer5_out_0_ap_vld,
    output logic                     layer5_out_1_ap_vld
);
    localparam int K_W = $clog2(N_SAMP);
    localparam int KSQ_W = 2 * K_W;
    localparam int S0_W = 24;
    localparam int S1_W = 31;
    localparam int S2_W = 38;
    localparam int FRAC = 16;
    localparam int D_W = S0_W + S2_W;
    localparam int Q_W = 2 * S0_W;
    localparam int NV_W = D_W + 2 * FRAC;
    localparam int RS_W = OUT_W + 1;
    localparam int ITER_DIV = Q_W;
    localparam int ITER_SQ = Q_W / 2;

    typedef enum logic [2:0] {IDLE, ACC, DIV, SQRT, DONE} state_t;

    state_t                     state;
    logic [6:0]                 cnt;
    logic [K_W-1:0]             k;
    logic [KSQ_W-1:0]           ksq;
    logic [N_SAMP*IN_W-1:0]     samp;
    logic [S0_W-1:0]            s0;
    logic [S1_W-1:0]            s1;
    logic [S2_W-1:0]            s2;
    logic                       ovf_v;
    logic [S0_W-1:0]            rem_m, div_m;
    logic [Q_W-1:0]             nq_m;
    logic [Q_W-1:0]             rem_v, div_v, nq_v;
    logic [RS_W-1:0]            rem_s;
    logic [OUT_W-1:0]           root;

    function automatic logic [OUT_W-1:0] sat_q(input logic [Q_W-1:0] q);
        return (q > Q_W'({OUT_W{1'b1}})) ? {OUT_W{1'b1}} : q[OUT_W-1:0];
    endfunction

    // Weight of the current sample: pedestal-subtracted, negatives clamped to zero
    logic signed [IN_W-1:0] x;
    logic signed [IN_W:0]   diff;
    logic [IN_W-1:0]        w;
    logic [S1_W-1:0]        prod1;
    logic [S2_W-1:0]        prod2;

    always_comb begin
        x = samp[IN_W-1:0];
        diff = {x[IN_W-1], x} - {BASELINE[IN_W-1], BASELINE};
        w = diff[IN_W] ? '0 : diff[IN_W-1:0];
        prod1 = S1_W'(k) * S1_W'(w);
        prod2 = S2_W'(ksq) * S2_W'(w);
    end

    logic [D_W-1:0]       d_val;
    logic [Q_W-1:0]       s0sq;
    logic [NV_W-1:0]      num_v;
    logic [NV_W-Q_W-1:0]  hi_v;

    always_comb begin
        d_val = D_W'(s0) * D_W'(s2) - D_W'(s1) * D_W'(s1);
        s0sq = Q_W'(s0) * Q_W'(s0);
        num_v = {d_val, {(2*FRAC){1'b0}}};
        hi_v = num_v[NV_W-1:Q_W];
    end

    // One restoring step for each divider and one digit step for the square root
    logic [S0_W:0]      trial_m;
    logic               ge_m;
    logic [S0_W-1:0]    rem_m_nx;
    logic [Q_W:0]       trial_v;
    logic               ge_v;
    logic [Q_W-1:0]     rem_v_nx;
    logic [RS_W+1:0]    trial_r, trial_d;
    logic               ge_s;
    logic [RS_W-1:0]    rem_s_nx;
    logic [OUT_W-1:0]   root_nx;

    always_comb begin
        trial_m = {rem_m, nq_m[Q_W-1]};
        ge_m = trial_m >= {1'b0, div_m};
        rem_m_nx = ge_m ? S0_W'(trial_m - {1'b0, div_m}) : trial_m[S0_W-1:0];

        trial_v = {rem_v, nq_v[Q_W-1]};
        ge_v = trial_v >= {1'b0, div_v};
        rem_v_nx = ge_v ? Q_W'(trial_v - {1'b0, div_v}) : trial_v[Q_W-1:0];

        trial_r = {rem_s, nq_v[Q_W-1 -: 2]};
        trial_d = (RS_W+2)'({root, 2'b01});
        ge_s = trial_r >= trial_d;
        rem_s_nx = ge_s ? RS_W'(trial_r - trial_d) : trial_r[RS_W-1:0];
        root_nx = {root[OUT_W-2:0], ge_s};
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= IDLE;
            cnt <= '0;
            k <= '0;
            ksq <= '0;
            samp <= '0;
            s0 <= '0;
            s1 <= '0;
            s2 <= '0;
            ovf_v <= 1'b0;
            rem_m <= '0;
            div_m <= '0;
            nq_m <= '0;
            rem_v <= '0;
            div_v <= '0;
            nq_v <= '0;
            rem_s <= '0;
            root <= '0;
            ap_done <= 1'b0;
            ap_idle <= 1'b1;
            ap_ready <= 1'b0;
            layer5_out_0 <= '0;
            layer5_out_1 <= '0;
            layer5_out_0_ap_vld <= 1'b0;
            layer5_out_1_ap_vld <= 1'b0;
        end else begin
            ap_ready <= 1'b0;
            ap_done <= 1'b0;
            layer5_out_0_ap_vld <= 1'b0;
            layer5_out_1_ap_vld <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (ap_start && input_1_ap_vld) begin
                        samp <= input_1;
                        s0 <= '0;
                        s1 <= '0;
                        s2 <= '0;
                        k <= '0;
                        ksq <= '0;
                        ap_ready <= 1'b1;
                        ap_idle <= 1'b0;
                        state <= ACC;
                    end else begin
                        ap_idle <= 1'b1;
                        state <= IDLE;
                    end
                end
                ACC: begin
                    s0 <= s0 + S0_W'(w);
                    s1 <= s1 + prod1;
                    s2 <= s2 + prod2;
                    samp <= samp >> IN_W;
                    k <= k + 1'b1;
                    ksq <= ksq + KSQ_W'({k, 1'b1});
                    if (k == K_W'(N_SAMP - 1)) begin
                        cnt <= '0;
                        state <= DIV;
                    end
                end
                // Both dividers run in lockstep; a zero S0 runs them anyway so latency stays fixed
                DIV: begin
                    if (cnt == '0) begin
                        rem_m <= '0;
                        div_m <= s0;
                        nq_m <= Q_W'(s1) << FRAC;
                        ovf_v <= Q_W'(hi_v) >= s0sq;
                        rem_v <= Q_W'(hi_v);
                        div_v <= s0sq;
                        nq_v <= num_v[Q_W-1:0];
                        rem_s <= '0;
                        root <= '0;
                    end else begin
                        rem_m <= rem_m_nx;
                        nq_m <= {nq_m[Q_W-2:0], ge_m};
                        rem_v <= rem_v_nx;
                        nq_v <= {nq_v[Q_W-2:0], ge_v};
                    end
                    if (cnt == 7'(ITER_DIV)) begin
                        cnt <= '0;
                        state <= SQRT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SQRT: begin
                    rem_s <= rem_s_nx;
                    root <= root_nx;
                    nq_v <= nq_v << 2;
                    if (cnt == 7'(ITER_SQ - 1)) begin
                        layer5_out_0 <= (s0 == '0) ? '0 : sat_q(nq_m);
                        layer5_out_1 <= (s0 == '0) ? '0 : (ovf_v ? {OUT_W{1'b1}} : root_nx);
                        ap_done <= 1'b1;
                        layer5_out_0_ap_vld <= 1'b1;
                        layer5_out_1_ap_vld <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    ap_idle <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_myproject.sv
// Directed bench for myproject: reference waveforms with hand-computed Mean/Sigma,
// handshake timing and mid-run reset.
module tb_myproject;
    localparam int N = 100;
    localparam int W = 18;

    logic              ap_clk = 1'b0;
    logic              ap_rst_n = 1'b1;
    logic              ap_start = 1'b0;
    logic              input_1_ap_vld = 1'b0;
    logic [N*W-1:0]    input_1 = '0;
    logic              ap_done, ap_idle, ap_ready;
    logic [23:0]       layer5_out_0, layer5_out_1;
    logic              layer5_out_0_ap_vld, layer5_out_1_ap_vld;

    int total = 0;
    int bad = 0;
    int n_ready = 0;
    int n_done = 0;

    myproject dut (
        .ap_clk(ap_clk),
        .ap_rst_n(ap_rst_n),
        .ap_start(ap_start),
        .ap_done(ap_done),
        .ap_idle(ap_idle),
        .ap_ready(ap_ready),
        .input_1(input_1),
        .input_1_ap_vld(input_1_ap_vld),
        .layer5_out_0(layer5_out_0),
        .layer5_out_1(layer5_out_1),
        .layer5_out_0_ap_vld(layer5_out_0_ap_vld),
        .layer5_out_1_ap_vld(layer5_out_1_ap_vld)
    );

    always #5 ap_clk = ~ap_clk;

    always @(negedge ap_clk) begin
        if (ap_ready === 1'b1) n_ready++;
        if (ap_done === 1'b1) n_done++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge ap_clk);
        #1;
    endtask

    task automatic wait_done(input string tag, inout int lat);
        while (ap_done !== 1'b1 && lat < 400) begin
            tick();
            lat++;
        end
        chk({tag, "/done"}, 32'(ap_done), 32'd1);
    endtask

    task automatic check_results(input string tag, input logic [23:0] em, input logic [23:0] es);
        int d;
        chk({tag, "/vld0"}, 32'(layer5_out_0_ap_vld), 32'd1);
        chk({tag, "/vld1"}, 32'(layer5_out_1_ap_vld), 32'd1);
        chk({tag, "/mean"}, 32'(layer5_out_0), 32'(em));
        d = int'(layer5_out_1) - int'(es);
        total++;
        assert (d >= -1 && d <= 1) else begin
            bad++;
            $error("FAIL %s/sigma: got %0h want %0h (+/-1)", tag, layer5_out_1, es);
        end
    endtask

    task automatic run_case(input string tag, input logic [N*W-1:0] vec,
                            input logic [23:0] em, input logic [23:0] es, output int lat);
        int r0, d0;
        r0 = n_ready;
        d0 = n_done;
        input_1 = vec;
        ap_start = 1'b1;
        input_1_ap_vld = 1'b1;
        tick();
        ap_start = 1'b0;
        input_1_ap_vld = 1'b0;
        input_1 = ~vec;
        chk({tag, "/ready"}, 32'(ap_ready), 32'd1);
        chk({tag, "/busy"}, 32'(ap_idle), 32'd0);
        lat = 0;
        wait_done(tag, lat);
        check_results(tag, em, es);
        tick();
        chk({tag, "/done_pulse"}, 32'(ap_done), 32'd0);
        chk({tag, "/vld_pulse"}, 32'(layer5_out_0_ap_vld | layer5_out_1_ap_vld), 32'd0);
        chk({tag, "/idle_after"}, 32'(ap_idle), 32'd1);
        chk({tag, "/hold"}, 32'(layer5_out_0), 32'(em));
        chk({tag, "/n_ready"}, 32'(n_ready - r0), 32'd1);
        chk({tag, "/n_done"}, 32'(n_done - d0), 32'd1);
    endtask

    logic [N*W-1:0] v1, v2, v3, v4, v5;
    int lat1, lat, r0, d0;

    initial begin
        v1 = '0;
        v2 = '0;
        v2[37*W +: W] = 18'h00400;
        v3 = '0;
        v3[10*W +: W] = 18'h00400;
        v3[20*W +: W] = 18'h00400;
        for (int i = 0; i < N; i++) begin
            v4[i*W +: W] = 18'h00400;
            v5[i*W +: W] = 18'h3FC00;
        end
        v5[5*W +: W] = 18'h00800;

        #3 ap_rst_n = 1'b0;
        #1;
        chk("rst/idle", 32'(ap_idle), 32'd1);
        chk("rst/done", 32'(ap_done), 32'd0);
        chk("rst/ready", 32'(ap_ready), 32'd0);
        chk("rst/out0", 32'(layer5_out_0), 32'd0);
        chk("rst/out1", 32'(layer5_out_1), 32'd0);
        chk("rst/vld", 32'(layer5_out_0_ap_vld | layer5_out_1_ap_vld), 32'd0);
        tick();
        tick();
        ap_rst_n = 1'b1;
        tick();

        run_case("t1_zero", v1, 24'h000000, 24'h000000, lat1);
        total++;
        assert (lat1 <= 256) else begin
            bad++;
            $error("FAIL t1/latency: got %0d want <=256", lat1);
        end
        run_case("t2_single", v2, 24'h250000, 24'h000000, lat);
        chk("t2/latency", 32'(lat), 32'(lat1));
        run_case("t3_pair", v3, 24'h0F0000, 24'h050000, lat);
        chk("t3/latency", 32'(lat), 32'(lat1));
        run_case("t4_flat", v4, 24'h318000, 24'h1CDDB6, lat);
        chk("t4/latency", 32'(lat), 32'(lat1));
        run_case("t5_neg", v5, 24'h050000, 24'h000000, lat);
        chk("t5/latency", 32'(lat), 32'(lat1));

        // Abort a run with reset partway through accumulation
        d0 = n_done;
        input_1 = v4;
        ap_start = 1'b1;
        input_1_ap_vld = 1'b1;
        tick();
        ap_start = 1'b0;
        input_1_ap_vld = 1'b0;
        repeat (20) tick();
        ap_rst_n = 1'b0;
        #1;
        chk("t5rst/out0", 32'(layer5_out_0), 32'd0);
        chk("t5rst/out1", 32'(layer5_out_1), 32'd0);
        chk("t5rst/idle", 32'(ap_idle), 32'd1);
        chk("t5rst/done", 32'(ap_done), 32'd0);
        tick();
        tick();
        ap_rst_n = 1'b1;
        repeat (250) tick();
        chk("t5rst/no_done", 32'(n_done - d0), 32'd0);
        chk("t5rst/idle_after", 32'(ap_idle), 32'd1);
        chk("t5rst/out0_after", 32'(layer5_out_0), 32'd0);

        // ap_start held while the valid qualifier arrives late
        r0 = n_ready;
        d0 = n_done;
        input_1 = v3;
        ap_start = 1'b1;
        input_1_ap_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t6/wait_idle%0d", i), 32'(ap_idle), 32'd1);
            chk($sformatf("t6/wait_ready%0d", i), 32'(ap_ready), 32'd0);
        end
        input_1_ap_vld = 1'b1;
        tick();
        chk("t6/ready", 32'(ap_ready), 32'd1);
        lat = 0;
        tick();
        lat++;
        input_1_ap_vld = 1'b0;
        input_1 = v4;
        wait_done("t6", lat);
        check_results("t6", 24'h0F0000, 24'h050000);
        chk("t6/latency", 32'(lat), 32'(lat1));
        tick();
        chk("t6/idle_no_vld", 32'(ap_idle), 32'd1);
        repeat (3) tick();
        chk("t6/still_idle", 32'(ap_idle), 32'd1);
        chk("t6/n_ready", 32'(n_ready - r0), 32'd1);
        chk("t6/n_done", 32'(n_done - d0), 32'd1);
        ap_start = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
